// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 serial transmitter.
package ws2812_pkg;

    localparam int PIXEL_W = 24;

    localparam int DEF_T0H_CYCLES   = 4;
    localparam int DEF_T1H_CYCLES   = 8;
    localparam int DEF_BIT_CYCLES   = 15;
    localparam int DEF_LATCH_CYCLES = 600;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_LATCH = 2'd3
    } shift_state_e;

    function automatic bit timing_ok(int t0h, int t1h, int bitc);
        return (t0h > 0) && (t0h < t1h) && (t1h < bitc);
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle counter: tells the shifter the next line level and when a bit ends.
module ws2812_bit_timer #(
    parameter int T0H_CYCLES = 4,
    parameter int T1H_CYCLES = 8,
    parameter int BIT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic start,
    input  logic bit_val,
    output logic hi_next,
    output logic bit_end
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM    = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] T0_LAST = CW'(T0H_CYCLES - 1);
    localparam logic [CW-1:0] T1_LAST = CW'(T1H_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          one_q, one_d;

    always_comb begin
        cnt_d = cnt_q;
        one_d = one_q;
        if (start) begin
            cnt_d = '0;
            one_d = bit_val;
        end else if (!run || cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Next cycle c+1 is high while c+1 < TH, i.e. c < TH-1.
    assign hi_next = cnt_q < (one_q ? T1_LAST : T0_LAST);
    assign bit_end = cnt_q == TERM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            one_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            one_q <= one_d;
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 pixel transmitter: valid/ready pixel input, one-entry hold, MSB-first shifter.
// Optional underrun pulse output when WS2812_TX_UNDERRUN_EN is defined.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_last,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    output logic               dout,
    output logic               busy
`ifdef WS2812_TX_UNDERRUN_EN
    ,
    output logic               underrun
`endif
);

    generate
        if (!timing_ok(T0H_CYCLES, T1H_CYCLES, BIT_CYCLES)) begin : g_bad_timing
            $error("ws2812_tx: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
        end
    endgenerate

    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int IW = $clog2(PIXEL_W);
    localparam logic [LW-1:0] LATCH_TERM = LW'(LATCH_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(PIXEL_W - 1);

    shift_state_e       state_q, state_d;
    logic [PIXEL_W-1:0] hold_q, hold_d;
    logic               hold_last_q, hold_last_d;
    logic               hold_full_q, hold_full_d;
    logic [PIXEL_W-1:0] shreg_q, shreg_d;
    logic               last_q, last_d;
    logic [IW-1:0]      bit_idx_q, bit_idx_d;
    logic [LW-1:0]      latch_cnt_q, latch_cnt_d;
    logic               dout_q, dout_d;

    logic accept;
    logic load;
    logic bit_start;
    logic bit_val;
    logic run;
    logic hi_next;
    logic bit_end;
`ifdef WS2812_TX_UNDERRUN_EN
    logic underrun_q, underrun_d;
`endif

    assign accept = pixel_valid && !hold_full_q;
    assign run    = (state_q == ST_HIGH) || (state_q == ST_LOW);

    ws2812_bit_timer #(
        .T0H_CYCLES(T0H_CYCLES),
        .T1H_CYCLES(T1H_CYCLES),
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .start  (bit_start),
        .bit_val(bit_val),
        .hi_next(hi_next),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        last_d      = last_q;
        bit_idx_d   = bit_idx_q;
        latch_cnt_d = latch_cnt_q;
        dout_d      = dout_q;
        load        = 1'b0;
        bit_start   = 1'b0;
        bit_val     = shreg_q[PIXEL_W-2];
`ifdef WS2812_TX_UNDERRUN_EN
        underrun_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                dout_d = 1'b0;
                load   = hold_full_q;
            end
            ST_HIGH, ST_LOW: begin
                if (!bit_end) begin
                    dout_d  = hi_next;
                    state_d = hi_next ? ST_HIGH : ST_LOW;
                end else if (bit_idx_q != IDX_LAST) begin
                    shreg_d   = shreg_q << 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    bit_start = 1'b1;
                    dout_d    = 1'b1;
                    state_d   = ST_HIGH;
                end else if (last_q) begin
                    dout_d  = 1'b0;
                    state_d = ST_LATCH;
                end else if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    dout_d  = 1'b0;
                    state_d = ST_IDLE;
`ifdef WS2812_TX_UNDERRUN_EN
                    underrun_d = 1'b1;
`endif
                end
            end
            ST_LATCH: begin
                dout_d = 1'b0;
                if (latch_cnt_q == LATCH_TERM) begin
                    latch_cnt_d = '0;
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    latch_cnt_d = latch_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dout_d  = 1'b0;
            end
        endcase
        // Load and accept are exclusive: load needs hold full, accept needs it empty.
        if (load) begin
            shreg_d     = hold_q;
            last_d      = hold_last_q;
            bit_idx_d   = '0;
            hold_full_d = 1'b0;
            bit_start   = 1'b1;
            bit_val     = hold_q[PIXEL_W-1];
            dout_d      = 1'b1;
            state_d     = ST_HIGH;
        end
        if (accept) begin
            hold_d      = pixel_data;
            hold_last_d = pixel_last;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            last_q      <= 1'b0;
            bit_idx_q   <= '0;
            latch_cnt_q <= '0;
            dout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            last_q      <= last_d;
            bit_idx_q   <= bit_idx_d;
            latch_cnt_q <= latch_cnt_d;
            dout_q      <= dout_d;
        end
    end

`ifdef WS2812_TX_UNDERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
`endif

    assign pixel_ready = !hold_full_q;
    assign busy        = (state_q != ST_IDLE) || hold_full_q;
    assign dout        = dout_q;

endmodule
